// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS control FSM (lw/sw/add, mul when MULTICYCLE_MUL_EN is defined)
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        mul_done,
    output logic        pc_clr,
    output logic        pc_write,
    output logic        ir_write,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        mul_sel,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        mul_start,
    output logic        done,
    output logic        err,
    output logic [3:0]  state,
    output logic [15:0] instr_count
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_MEMADR  = 4'd3;
    localparam logic [3:0] S_MEMRD   = 4'd4;
    localparam logic [3:0] S_MEMWB   = 4'd5;
    localparam logic [3:0] S_MEMWR   = 4'd6;
    localparam logic [3:0] S_RTEXE   = 4'd7;
`ifdef MULTICYCLE_MUL_EN
    localparam logic [3:0] S_MULWAIT = 4'd8;
`endif
    localparam logic [3:0] S_RTWB    = 4'd9;
    localparam logic [3:0] S_HALT    = 4'd10;
    localparam logic [3:0] S_ERR     = 4'd11;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] FN_ADD    = 6'b100000;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       op_lw;
    logic       op_sw;
    logic       op_add;
    logic       launch;

    assign state  = state_q;
    assign op_lw  = (instr[31:26] == OP_LW);
    assign op_sw  = (instr[31:26] == OP_SW);
    assign op_add = (instr[31:26] == OP_RTYPE) && (instr[5:0] == FN_ADD);

    // IDLE and HALT restart identically; gated by rst_n so nothing leaks out during reset
    assign launch = rst_n && start && ((state_q == S_IDLE) || (state_q == S_HALT));

`ifdef MULTICYCLE_MUL_EN
    localparam logic [5:0] FN_MUL = 6'b011000;

    logic op_mul;
    logic is_mul;
    logic mul_issued;

    assign op_mul = (instr[31:26] == OP_RTYPE) && (instr[5:0] == FN_MUL);

    // mul_issued marks that the launch cycle of the current MULWAIT visit has passed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_issued <= 1'b0;
            is_mul     <= 1'b0;
        end else begin
            mul_issued <= (state_q == S_MULWAIT);
            if ((state_q == S_MULWAIT) && mul_done)
                is_mul <= 1'b1;
            else if (state_q == S_RTWB)
                is_mul <= 1'b0;
        end
    end
`else
    logic unused_mul_done;
    assign unused_mul_done = mul_done;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_FETCH + 4'd1;
            S_DECODE: begin
                if (instr == 32'd0)
                    state_d = S_HALT;
                else if (op_lw || op_sw)
                    state_d = S_MEMADR;
                else if (op_add)
                    state_d = S_RTEXE;
`ifdef MULTICYCLE_MUL_EN
                else if (op_mul)
                    state_d = S_MULWAIT;
`endif
                else
                    state_d = S_ERR;
            end
            S_MEMADR: state_d = op_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_RTEXE:  state_d = S_RTWB;
`ifdef MULTICYCLE_MUL_EN
            S_MULWAIT: if (mul_done) state_d = S_RTWB;
`endif
            S_RTWB:   state_d = S_FETCH;
            S_HALT:   if (start) state_d = S_FETCH;
            S_ERR:    state_d = S_ERR;
            default:  state_d = S_ERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instr_count <= 16'd0;
        else if (launch)
            instr_count <= 16'd0;
        else if ((state_q == S_FETCH) && mem_ready && (instr_count != 16'hFFFF))
            instr_count <= instr_count + 16'd1;
    end

    always_comb begin
        pc_clr     = launch;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        mul_sel    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        mul_start  = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_RTEXE: alu_src_a = 1'b1;
`ifdef MULTICYCLE_MUL_EN
            S_MULWAIT: mul_start = !mul_issued;
`endif
            S_RTWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
`ifdef MULTICYCLE_MUL_EN
                mul_sel   = is_mul;
`endif
            end
            S_HALT:  done = 1'b1;
            S_ERR:   err  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] instr;
    logic        mem_ready;
    logic        mul_done;
    logic        pc_clr, pc_write, ir_write, iord, mem_read, mem_write;
    logic        reg_write, reg_dst, mem_to_reg, mul_sel, alu_src_a;
    logic [1:0]  alu_src_b;
    logic        mul_start, done, err;
    logic [3:0]  state;
    logic [15:0] instr_count;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
        .mem_ready(mem_ready), .mul_done(mul_done),
        .pc_clr(pc_clr), .pc_write(pc_write), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .mul_sel(mul_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .mul_start(mul_start),
        .done(done), .err(err), .state(state), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    localparam logic [15:0] PCCLR  = 16'h8000;
    localparam logic [15:0] PCW    = 16'h4000;
    localparam logic [15:0] IRW    = 16'h2000;
    localparam logic [15:0] IORD   = 16'h1000;
    localparam logic [15:0] MRD    = 16'h0800;
    localparam logic [15:0] MWR    = 16'h0400;
    localparam logic [15:0] REGW   = 16'h0200;
    localparam logic [15:0] REGDST = 16'h0100;
    localparam logic [15:0] M2R    = 16'h0080;
    localparam logic [15:0] MULSEL = 16'h0040;
    localparam logic [15:0] SRCA   = 16'h0020;
    localparam logic [15:0] B10    = 16'h0010;
    localparam logic [15:0] B01    = 16'h0008;
    localparam logic [15:0] MULST  = 16'h0004;
    localparam logic [15:0] DONE   = 16'h0002;
    localparam logic [15:0] ERRO   = 16'h0001;
    localparam logic [15:0] FETCH_WAIT = MRD | B01;
    localparam logic [15:0] FETCH_GO   = MRD | B01 | IRW | PCW;

    localparam logic [31:0] I_LW  = 32'h8D10_0200;
    localparam logic [31:0] I_SW  = 32'hADD0_0100;
    localparam logic [31:0] I_ADD = 32'h012A_4020;
    localparam logic [31:0] I_MUL = 32'h01C9_4818;
    localparam logic [31:0] I_J   = 32'h0800_0000;

    typedef struct {
        int          step;
        logic [3:0]  st;
        logic [15:0] outs;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;

    logic [15:0] obs;
    assign obs = {pc_clr, pc_write, ir_write, iord, mem_read, mem_write, reg_write,
                  reg_dst, mem_to_reg, mul_sel, alu_src_a, alu_src_b, mul_start, done, err};

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (state !== e.st) begin
                failures++;
                $display("FAIL state step=%0d got=%0d exp=%0d", e.step, state, e.st);
            end
            checks++;
            if (obs !== e.outs) begin
                failures++;
                $display("FAIL outputs step=%0d got=%h exp=%h", e.step, obs, e.outs);
            end
            checks++;
            if (instr_count !== e.cnt) begin
                failures++;
                $display("FAIL instr_count step=%0d got=%0d exp=%0d", e.step, instr_count, e.cnt);
            end
        end
    end

    task automatic cyc(input logic r, input logic st, input logic mr, input logic md,
                       input logic [31:0] ins, input logic [3:0] es,
                       input logic [15:0] eo, input logic [15:0] ec);
        exp_t e;
        rst_n     = r;
        start     = st;
        mem_ready = mr;
        mul_done  = md;
        instr     = ins;
        e.step = step_no;
        e.st   = es;
        e.outs = eo;
        e.cnt  = ec;
        q.push_back(e);
        step_no++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0; mul_done = 1'b0; instr = 32'd0;
        @(posedge clk);
        #1;
        // reset holds IDLE with everything low even with start raised
        cyc(0, 1, 1, 0, I_LW, 4'd0, 16'h0, 16'd0);
        cyc(1, 0, 0, 0, I_LW, 4'd0, 16'h0, 16'd0);
        cyc(1, 1, 0, 0, I_LW, 4'd0, PCCLR, 16'd0);
        // lw, zero-wait
        cyc(1, 0, 1, 0, I_LW, 4'd1, FETCH_GO, 16'd0);
        cyc(1, 0, 1, 0, I_LW, 4'd2, 16'h0, 16'd1);
        cyc(1, 0, 1, 0, I_LW, 4'd3, SRCA | B10, 16'd1);
        cyc(1, 0, 1, 0, I_LW, 4'd4, IORD | MRD, 16'd1);
        cyc(1, 0, 1, 0, I_LW, 4'd5, REGW | M2R, 16'd1);
        // fetch wait with a stray mul_done that must be ignored
        cyc(1, 0, 0, 1, I_SW, 4'd1, FETCH_WAIT, 16'd1);
        cyc(1, 0, 1, 0, I_SW, 4'd1, FETCH_GO, 16'd1);
        // sw with three wait cycles
        cyc(1, 0, 0, 0, I_SW, 4'd2, 16'h0, 16'd2);
        cyc(1, 0, 0, 0, I_SW, 4'd3, SRCA | B10, 16'd2);
        cyc(1, 0, 0, 0, I_SW, 4'd6, IORD | MWR, 16'd2);
        cyc(1, 0, 0, 0, I_SW, 4'd6, IORD | MWR, 16'd2);
        cyc(1, 0, 0, 0, I_SW, 4'd6, IORD | MWR, 16'd2);
        cyc(1, 0, 1, 0, I_SW, 4'd6, IORD | MWR, 16'd2);
        // add
        cyc(1, 0, 1, 0, I_ADD, 4'd1, FETCH_GO, 16'd2);
        cyc(1, 0, 1, 0, I_ADD, 4'd2, 16'h0, 16'd3);
        cyc(1, 0, 1, 0, I_ADD, 4'd7, SRCA, 16'd3);
        cyc(1, 0, 1, 0, I_ADD, 4'd9, REGW | REGDST, 16'd3);
        // halt, then restart from HALT
        cyc(1, 0, 1, 0, 32'd0, 4'd1, FETCH_GO, 16'd3);
        cyc(1, 0, 1, 0, 32'd0, 4'd2, 16'h0, 16'd4);
        cyc(1, 0, 1, 0, 32'd0, 4'd10, DONE, 16'd4);
        cyc(1, 1, 1, 0, 32'd0, 4'd10, DONE | PCCLR, 16'd4);
        cyc(1, 0, 1, 0, I_MUL, 4'd1, FETCH_GO, 16'd0);
        cyc(1, 0, 1, 0, I_MUL, 4'd2, 16'h0, 16'd1);
`ifdef MULTICYCLE_MUL_EN
        cyc(1, 0, 1, 0, I_MUL, 4'd8, MULST, 16'd1);
        for (int i = 0; i < 5; i++)
            cyc(1, 0, 1, 0, I_MUL, 4'd8, 16'h0, 16'd1);
        cyc(1, 0, 1, 1, I_MUL, 4'd8, 16'h0, 16'd1);
        cyc(1, 0, 1, 0, I_MUL, 4'd9, REGW | REGDST | MULSEL, 16'd1);
        // an add after mul must not select the multiplier result
        cyc(1, 0, 1, 0, I_ADD, 4'd1, FETCH_GO, 16'd1);
        cyc(1, 0, 1, 0, I_ADD, 4'd2, 16'h0, 16'd2);
        cyc(1, 0, 1, 0, I_ADD, 4'd7, SRCA, 16'd2);
        cyc(1, 0, 1, 0, I_ADD, 4'd9, REGW | REGDST, 16'd2);
`else
        cyc(1, 0, 1, 1, I_MUL, 4'd11, ERRO, 16'd1);
        cyc(1, 1, 1, 0, I_MUL, 4'd11, ERRO, 16'd1);
`endif
        // illegal opcode -> ERR, start ignored, reset clears
        cyc(0, 0, 0, 0, I_J, 4'd0, 16'h0, 16'd0);
        cyc(1, 1, 0, 0, I_J, 4'd0, PCCLR, 16'd0);
        cyc(1, 0, 1, 0, I_J, 4'd1, FETCH_GO, 16'd0);
        cyc(1, 0, 1, 0, I_J, 4'd2, 16'h0, 16'd1);
        cyc(1, 1, 1, 0, I_J, 4'd11, ERRO, 16'd1);
        cyc(1, 0, 1, 0, I_J, 4'd11, ERRO, 16'd1);
        cyc(1, 1, 1, 0, I_J, 4'd11, ERRO, 16'd1);
        cyc(0, 0, 0, 0, I_J, 4'd0, 16'h0, 16'd0);
        // reset mid-MEMRD must clear outputs within the cycle
        cyc(1, 1, 0, 0, I_LW, 4'd0, PCCLR, 16'd0);
        cyc(1, 0, 1, 0, I_LW, 4'd1, FETCH_GO, 16'd0);
        cyc(1, 0, 0, 0, I_LW, 4'd2, 16'h0, 16'd1);
        cyc(1, 0, 0, 0, I_LW, 4'd3, SRCA | B10, 16'd1);
        cyc(1, 0, 0, 0, I_LW, 4'd4, IORD | MRD, 16'd1);
        cyc(0, 0, 0, 0, I_LW, 4'd0, 16'h0, 16'd0);
        cyc(0, 0, 0, 0, I_LW, 4'd0, 16'h0, 16'd0);

        for (int i = 0; i < 10 && q.size() != 0; i++)
            @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
